// File: rtl/vx_ifetch_pkg.sv
// Shared types and helpers for the instruction-fetch request concentrator.
// The request struct below uses default widths; width-specific users override it.
package vx_ifetch_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int DEF_UUID_BITS   = 44;
  localparam int DEF_NUM_THREADS = 4;
  localparam int DEF_NW_BITS     = 2;
  localparam int DEF_PC_BITS     = 32;

  typedef struct packed {
    logic [DEF_UUID_BITS-1:0]   uuid;
    logic [DEF_NUM_THREADS-1:0] tmask;
    logic [DEF_NW_BITS-1:0]     wid;
    logic [DEF_PC_BITS-1:0]     PC;
  } ifetch_req_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_ifetch_req_fifo.sv
// Per-channel request FIFO: power-of-two depth, registered fill count,
// synchronous flush that drops everything including a same-cycle push.
module vx_ifetch_req_fifo
  import vx_ifetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type req_t = ifetch_req_t,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  req_t             din,
  output req_t             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  req_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/vx_ifetch_req_arb.sv
// Fetch-request concentrator: per-channel FIFOs, round-robin or fixed-priority
// arbitration into a single registered output stage tagged with the source channel.
module vx_ifetch_req_arb
  import vx_ifetch_pkg::*;
#(
  parameter int  NUM_REQS    = 4,
  parameter int  BUF_DEPTH   = 2,
  parameter int  UUID_BITS   = 44,
  parameter int  NUM_THREADS = 4,
  parameter int  NW_BITS     = 2,
  parameter int  PC_BITS     = 32,
  parameter int  ARB_MODE    = 0,
  localparam int IDX_W       = idx_width(NUM_REQS),
  localparam int CNT_W       = $clog2(BUF_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            flush,
  input  logic [NUM_REQS-1:0]             in_valid,
  input  logic [NUM_REQS*UUID_BITS-1:0]   in_uuid,
  input  logic [NUM_REQS*NUM_THREADS-1:0] in_tmask,
  input  logic [NUM_REQS*NW_BITS-1:0]     in_wid,
  input  logic [NUM_REQS*PC_BITS-1:0]     in_PC,
  output logic [NUM_REQS-1:0]             in_ready,
  output logic                            out_valid,
  output logic [UUID_BITS-1:0]            out_uuid,
  output logic [NUM_THREADS-1:0]          out_tmask,
  output logic [NW_BITS-1:0]              out_wid,
  output logic [PC_BITS-1:0]              out_PC,
  output logic [IDX_W-1:0]                out_idx,
  input  logic                            out_ready,
  output logic [NUM_REQS*CNT_W-1:0]       occupancy
);

  typedef struct packed {
    logic [UUID_BITS-1:0]   uuid;
    logic [NUM_THREADS-1:0] tmask;
    logic [NW_BITS-1:0]     wid;
    logic [PC_BITS-1:0]     PC;
  } req_t;

  req_t                in_req [NUM_REQS];
  req_t                head   [NUM_REQS];
  logic [NUM_REQS-1:0] full, empty, push, pop;
  logic [CNT_W-1:0]    count  [NUM_REQS];

  req_t                out_req_q, out_req_d;
  logic                out_valid_q, out_valid_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;
  logic [IDX_W-1:0]    rr_q, rr_d;

  logic                load_en, any_vld, grant;
  logic [IDX_W-1:0]    win, cand;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_ch
    assign in_req[i].uuid  = in_uuid[i*UUID_BITS +: UUID_BITS];
    assign in_req[i].tmask = in_tmask[i*NUM_THREADS +: NUM_THREADS];
    assign in_req[i].wid   = in_wid[i*NW_BITS +: NW_BITS];
    assign in_req[i].PC    = in_PC[i*PC_BITS +: PC_BITS];

    // Ready depends only on the registered fill count and flush.
    assign in_ready[i] = !full[i] && !flush;
    assign push[i]     = in_valid[i] && in_ready[i];
    assign pop[i]      = grant && (win == IDX_W'(i));
    assign occupancy[i*CNT_W +: CNT_W] = count[i];

    vx_ifetch_req_fifo #(
      .DEPTH (BUF_DEPTH),
      .req_t (req_t)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .push    (push[i]),
      .pop     (pop[i]),
      .din     (in_req[i]),
      .dout    (head[i]),
      .full    (full[i]),
      .empty   (empty[i]),
      .count   (count[i])
    );
  end

  assign load_en = !out_valid_q || out_ready;
  assign any_vld = |(~empty);
  assign grant   = load_en && any_vld && !flush;

  always_comb begin
    win  = '0;
    cand = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      // Scanning downward lets the first candidate in search order win last.
      if (ARB_MODE == ARB_FIXED) cand = IDX_W'(k);
      else                       cand = IDX_W'((int'(rr_q) + k) % NUM_REQS);
      if (!empty[cand]) win = cand;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_req_d   = out_req_q;
    out_idx_d   = out_idx_q;
    rr_d        = rr_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load_en) begin
      out_valid_d = any_vld;
      if (any_vld) begin
        out_req_d = head[win];
        out_idx_d = win;
        if (ARB_MODE == ARB_RR)
          rr_d = (win == IDX_W'(NUM_REQS - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_req_q   <= '0;
      out_idx_q   <= '0;
      rr_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_req_q   <= out_req_d;
      out_idx_q   <= out_idx_d;
      rr_q        <= rr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_uuid  = out_req_q.uuid;
  assign out_tmask = out_req_q.tmask;
  assign out_wid   = out_req_q.wid;
  assign out_PC    = out_req_q.PC;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_vx_ifetch_req_arb.sv
// Bench for vx_ifetch_req_arb: a round-robin and a fixed-priority instance share
// stimulus; a queue-based model is checked every cycle plus literal expectations.
module tb_vx_ifetch_req_arb;

  localparam int N   = 4;
  localparam int D   = 2;
  localparam int UB  = 44;
  localparam int NT  = 4;
  localparam int NWB = 2;
  localparam int PCB = 32;
  localparam int PW  = UB + NT + NWB + PCB;

  typedef logic [PW-1:0] pkt_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic [N-1:0]     in_valid = '0;
  logic [N*UB-1:0]  in_uuid = '0;
  logic [N*NT-1:0]  in_tmask = '0;
  logic [N*NWB-1:0] in_wid = '0;
  logic [N*PCB-1:0] in_PC = '0;

  logic [N-1:0]     in_ready_r, in_ready_f;
  logic             out_valid_r, out_valid_f;
  logic [UB-1:0]    out_uuid_r, out_uuid_f;
  logic [NT-1:0]    out_tmask_r, out_tmask_f;
  logic [NWB-1:0]   out_wid_r, out_wid_f;
  logic [PCB-1:0]   out_PC_r, out_PC_f;
  logic [1:0]       out_idx_r, out_idx_f;
  logic [7:0]       occ_r, occ_f;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vx_ifetch_req_arb #(.NUM_REQS(N), .BUF_DEPTH(D), .ARB_MODE(0)) dut_rr (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_uuid(in_uuid), .in_tmask(in_tmask), .in_wid(in_wid), .in_PC(in_PC),
    .in_ready(in_ready_r), .out_valid(out_valid_r), .out_uuid(out_uuid_r), .out_tmask(out_tmask_r),
    .out_wid(out_wid_r), .out_PC(out_PC_r), .out_idx(out_idx_r), .out_ready(out_ready),
    .occupancy(occ_r));

  vx_ifetch_req_arb #(.NUM_REQS(N), .BUF_DEPTH(D), .ARB_MODE(1)) dut_fx (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_uuid(in_uuid), .in_tmask(in_tmask), .in_wid(in_wid), .in_PC(in_PC),
    .in_ready(in_ready_f), .out_valid(out_valid_f), .out_uuid(out_uuid_f), .out_tmask(out_tmask_f),
    .out_wid(out_wid_f), .out_PC(out_PC_f), .out_idx(out_idx_f), .out_ready(out_ready),
    .occupancy(occ_f));

  // Model state: index m = 0 round-robin, m = 1 fixed priority.
  pkt_t mq [2*N][$];
  bit   mov  [2];
  pkt_t mdat [2];
  int   midx [2];
  int   mrr  [2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic pkt_t in_pkt(input int ch);
    return {in_uuid[ch*UB +: UB], in_tmask[ch*NT +: NT], in_wid[ch*NWB +: NWB], in_PC[ch*PCB +: PCB]};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mov[m] = 1'b0; mdat[m] = '0; midx[m] = 0; mrr[m] = 0;
      for (int i = 0; i < N; i++) mq[m*N+i].delete();
    end
  endtask

  task automatic model_step();
    bit acc [N];
    int w;
    int c;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (flush) begin
        for (int i = 0; i < N; i++) mq[m*N+i].delete();
        mov[m] = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) acc[i] = in_valid[i] && (mq[m*N+i].size() < D);
        if (!mov[m] || out_ready) begin
          w = -1;
          for (int k = 0; k < N; k++) begin
            c = (m == 0) ? (mrr[m] + k) % N : k;
            if (w < 0 && mq[m*N+c].size() > 0) w = c;
          end
          if (w >= 0) begin
            mdat[m] = mq[m*N+w].pop_front();
            mov[m]  = 1'b1;
            midx[m] = w;
            if (m == 0) mrr[m] = (w + 1) % N;
          end else begin
            mov[m] = 1'b0;
          end
        end
        for (int i = 0; i < N; i++) if (acc[i]) mq[m*N+i].push_back(in_pkt(i));
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] ir, eir;
    logic         ov;
    pkt_t         dat;
    logic [1:0]   idx;
    logic [7:0]   occ, eocc;
    string        tag;
    for (int m = 0; m < 2; m++) begin
      tag = (m == 0) ? "rr" : "fx";
      if (m == 0) begin
        ir = in_ready_r; ov = out_valid_r; idx = out_idx_r; occ = occ_r;
        dat = {out_uuid_r, out_tmask_r, out_wid_r, out_PC_r};
      end else begin
        ir = in_ready_f; ov = out_valid_f; idx = out_idx_f; occ = occ_f;
        dat = {out_uuid_f, out_tmask_f, out_wid_f, out_PC_f};
      end
      for (int i = 0; i < N; i++) begin
        eocc[i*2 +: 2] = 2'(mq[m*N+i].size());
        eir[i] = (mq[m*N+i].size() < D) && !flush;
      end
      chk({tag, " out_valid"}, 128'(ov), 128'(mov[m]));
      chk({tag, " in_ready"}, 128'(ir), 128'(eir));
      chk({tag, " occupancy"}, 128'(occ), 128'(eocc));
      if (mov[m]) begin
        chk({tag, " out_data"}, 128'(dat), 128'(mdat[m]));
        chk({tag, " out_idx"}, 128'(idx), 128'(midx[m]));
      end
    end
  endtask

  // Advance one clock: model updates at the edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_req(input int ch, input logic [31:0] pc, input logic [1:0] wid,
                         input logic [43:0] uuid, input logic [3:0] tm);
    in_uuid[ch*UB +: UB]    = uuid;
    in_tmask[ch*NT +: NT]   = tm;
    in_wid[ch*NWB +: NWB]   = wid;
    in_PC[ch*PCB +: PCB]    = pc;
  endtask

  int   seq_r [16];
  int   seq_f [16];
  int   nr, nf;
  int   exp_rr [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int   exp_fx [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  pkt_t snap;

  initial begin
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Idle after reset
    chk("reset out_valid rr", 128'(out_valid_r), 128'(0));
    chk("reset out_valid fx", 128'(out_valid_f), 128'(0));
    chk("reset in_ready", 128'(in_ready_r), 128'(4'hF));
    chk("reset occupancy rr", 128'(occ_r), 128'(0));
    chk("reset occupancy fx", 128'(occ_f), 128'(0));

    // Single request on channel 2
    out_ready = 1'b1;
    set_req(2, 32'h8000_0000, 2'd2, 44'h2A, 4'hF);
    in_valid = 4'b0100;
    tick();
    in_valid = '0;
    chk("lat1 out_valid", 128'(out_valid_r), 128'(0));
    chk("lat1 occ2", 128'(occ_r[5:4]), 128'(1));
    tick();
    chk("lat2 out_valid", 128'(out_valid_r), 128'(1));
    chk("lat2 out_PC", 128'(out_PC_r), 128'(32'h8000_0000));
    chk("lat2 out_wid", 128'(out_wid_r), 128'(2));
    chk("lat2 out_idx rr", 128'(out_idx_r), 128'(2));
    chk("lat2 out_idx fx", 128'(out_idx_f), 128'(2));
    chk("lat2 occupancy", 128'(occ_r), 128'(0));
    tick();
    chk("lat3 drained", 128'(out_valid_r), 128'(0));

    // Mid-operation reset, then two entries on every channel
    reset_n = 1'b0;
    out_ready = 1'b0;
    model_reset();
    tick();
    chk("midreset out_valid", 128'(out_valid_r), 128'(0));
    reset_n = 1'b1;
    tick();
    for (int e = 0; e < 2; e++) begin
      for (int ch = 0; ch < N; ch++)
        set_req(ch, 32'h1000 + 32'(ch*16 + e*4), 2'(ch), 44'(ch*16 + e), 4'(1 << ch));
      in_valid = 4'hF;
      tick();
    end
    in_valid = '0;
    chk("fill occupancy rr", 128'(occ_r), 128'(8'b1010_1001));
    chk("fill head idx", 128'(out_idx_r), 128'(0));
    out_ready = 1'b1;
    nr = 0;
    nf = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid_r && nr < 16) begin seq_r[nr] = int'(out_idx_r); nr++; end
      if (out_valid_f && nf < 16) begin seq_f[nf] = int'(out_idx_f); nf++; end
      tick();
    end
    chk("rr grant count", 128'(nr), 128'(8));
    chk("fx grant count", 128'(nf), 128'(8));
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("rr seq[%0d]", j), 128'(seq_r[j]), 128'(exp_rr[j]));
      chk($sformatf("fx seq[%0d]", j), 128'(seq_f[j]), 128'(exp_fx[j]));
    end
    chk("after burst out_valid", 128'(out_valid_r), 128'(0));

    // Stall with channel 1 pushing fresh data every cycle
    out_ready = 1'b0;
    snap = '0;
    for (int s = 0; s < 8; s++) begin
      set_req(1, 32'h2000 + 32'(s*4), 2'd1, 44'(256 + s), 4'h3);
      in_valid = 4'b0010;
      tick();
      if (s == 1) snap = {out_uuid_r, out_tmask_r, out_wid_r, out_PC_r};
      if (s > 1) chk($sformatf("stall stable %0d", s),
                     128'({out_uuid_r, out_tmask_r, out_wid_r, out_PC_r}), 128'(snap));
    end
    chk("stall PC", 128'(out_PC_r), 128'(32'h2000));
    chk("stall occ1", 128'(occ_r[3:2]), 128'(2));
    chk("stall in_ready", 128'(in_ready_r), 128'(4'b1101));

    // Flush with pushes offered in the same cycle
    flush = 1'b1;
    in_valid = 4'hF;
    tick();
    flush = 1'b0;
    in_valid = '0;
    chk("flush out_valid rr", 128'(out_valid_r), 128'(0));
    chk("flush out_valid fx", 128'(out_valid_f), 128'(0));
    chk("flush occupancy rr", 128'(occ_r), 128'(0));
    chk("flush occupancy fx", 128'(occ_f), 128'(0));

    // Pointer survives flush: it sits at 2, so channel 3 beats channel 0
    out_ready = 1'b1;
    set_req(0, 32'h3000, 2'd0, 44'h300, 4'h1);
    set_req(3, 32'h3300, 2'd3, 44'h333, 4'h8);
    in_valid = 4'b1001;
    tick();
    in_valid = '0;
    tick();
    chk("post-flush 1st idx rr", 128'(out_idx_r), 128'(3));
    chk("post-flush 1st PC rr", 128'(out_PC_r), 128'(32'h3300));
    chk("post-flush 1st idx fx", 128'(out_idx_f), 128'(0));
    tick();
    chk("post-flush 2nd idx rr", 128'(out_idx_r), 128'(0));
    chk("post-flush 2nd idx fx", 128'(out_idx_f), 128'(3));
    tick();
    chk("post-flush drained", 128'(out_valid_r), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_ifetch_req_arb.md
Name: vx_ifetch_req_arb

Overview:
- Multi-channel instruction-fetch request concentrator between NUM_REQS warp-scheduler fetch channels and the single icache request port.
- Each channel has a parametrised-depth FIFO.
- A round-robin or fixed-priority arbiter selects one entry per cycle into a registered output stage, tagged with its source channel index.
- Adds buffering, arbitration, flush and per-channel occupancy reporting, which a plain fetch-request channel lacks.

Parameters:
- NUM_REQS, 4, number of input fetch channels (1..16).
- BUF_DEPTH, 2, entries per channel FIFO (power of two, >=2).
- UUID_BITS, 44, request uuid width.
- NUM_THREADS, 4, thread-mask width.
- NW_BITS, 2, warp-id width.
- PC_BITS, 32, program-counter width.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all buffered requests.
- in_valid  in  NUM_REQS  per-channel request valid.
- in_uuid  in  NUM_REQS*UUID_BITS  per-channel uuid.
- in_tmask  in  NUM_REQS*NUM_THREADS  per-channel thread mask.
- in_wid  in  NUM_REQS*NW_BITS  per-channel warp id.
- in_PC  in  NUM_REQS*PC_BITS  per-channel PC.
- in_ready  out  NUM_REQS  per-channel accept.
- out_valid  out  1  output request valid.
- out_uuid  out  UUID_BITS.
- out_tmask  out  NUM_THREADS.
- out_wid  out  NW_BITS.
- out_PC  out  PC_BITS.
- out_idx  out  clog2(NUM_REQS) (min 1)  source channel of the output request.
- out_ready  in  1  downstream accept.
- occupancy  out  NUM_REQS*clog2(BUF_DEPTH+1)  per-channel FIFO fill count.

Behaviour:
- Reset is asynchronous, active-low: one clock, clk; reset_n asserted low clears state immediately without a clock edge.
- Reset values: all FIFOs empty; occupancy = 0; out_valid = 0; out_* data = 0; RR pointer = 0; in_ready = all-ones.
- in_ready[i] = !full[i] && !flush.
  - Derived from registered count only; no combinational path from out_ready or in_valid.
- Push on channel i when in_valid[i] && in_ready[i]. Channels push independently and may all push in the same cycle.
- Output stage is a single register. Load is allowed when the stage is empty or is being drained (out_valid && out_ready) in the same cycle.
- Arbitration on load considers only channels with non-empty FIFOs.
  - ARB_MODE=0: search starts at the RR pointer, wrapping modulo NUM_REQS; on grant, pointer <= winner+1 mod NUM_REQS. Pointer holds when there is no grant.
  - ARB_MODE=1: lowest non-empty index wins; pointer unused.
- Granted FIFO pops its head in the same cycle; the output register takes head fields and out_idx = winner.
- Latency: input handshake at edge T -> out_valid high after edge T+1 (2 cycles). Sustained throughput is 1 request/cycle.
- While out_valid && !out_ready, all out_* fields are stable and no pop occurs.
- Same-channel push and pop in one cycle: occupancy unchanged. When full, push is blocked even if a pop happens that cycle, because in_ready comes from the registered count.
- FIFO pointers wrap modulo BUF_DEPTH.
- Empty FIFO never pops; full FIFO never pushes.
- flush = 1 at an edge: all FIFOs emptied, occupancy = 0, out_valid <= 0.
  - Pushes and loads in that cycle are discarded.
  - A handshake with out_ready in the flush cycle counts as consumed.
  - RR pointer is preserved.
- reset_n asserted mid-operation: all state returns to reset values; in-flight requests are lost.
- NUM_REQS = 1: arbiter degenerates to pass-through; out_idx = 0.

Decomposition:
- Shared package vx_ifetch_pkg:
  - typedef ifetch_req_t {uuid, tmask, wid, PC} using the width parameters.
  - function for index width: clog2 with minimum 1.
  - constants ARB_RR = 0, ARB_FIXED = 1.
- Sub-module vx_ifetch_req_fifo: one per channel; BUF_DEPTH entries of ifetch_req_t with push/pop/full/empty/count and synchronous flush.
- Arbiter and output register stay in the top module.

Test Plan:
- Reset release, no traffic -> out_valid = 0, in_ready = 4'b1111, occupancy = 0 for all channels.
- Channel 2 pushes PC = 0x80000000, wid = 2, out_ready = 1 -> out_valid in the 2nd cycle with PC = 0x80000000 and out_idx = 2; occupancy[2] returns to 0.
- ARB_MODE=0, all 4 channels hold 2 entries, out_ready = 1 -> out_idx sequence 0,1,2,3,0,1,2,3, then out_valid = 0.
- ARB_MODE=1, same stimulus -> out_idx sequence 0,0,1,1,2,2,3,3.
- out_ready held 0 with channel 1 pushing -> occupancy[1] reaches BUF_DEPTH and in_ready[1] = 0; out_* fields are stable for every stalled cycle.
- flush while 3 entries are buffered and out_valid = 1 -> next cycle out_valid = 0 and all occupancy = 0. A subsequent push appears with RR order continuing from the preserved pointer.
